rom_arbiter: RTL and testbench

Two-port arbiter that shares the single combinational word-read port of the instruction ROM between the instruction-fetch requester (`if_`) and the data-load requester (`d_`). Each side uses a valid/ready request handshake and a registered, back-pressurable response. Data loads win by default, and a starvation counter guarantees fetch progress. The block sits between the fetch stage / load-store unit and the ROM. It drives the ROM address and captures ROM output one cycle after the grant.

---
 rtl/rom_pkg.sv | 20 ++
 rtl/rom_resp_slot.sv | 28 ++
 rtl/rom_arbiter.sv | 107 ++++++++++
 tb/tb_rom_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Provides default ROM geometry, the grant encoding and the response bundle.
package rom_pkg;

    localparam logic [31:0] ROM_START = 32'hBFC0_0000;
    localparam int          ROM_SIZE  = 4096;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_IF,
        GRANT_D
    } grant_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } rom_resp_t;

endpackage

// File: rtl/rom_resp_slot.sv
// One registered response slot: loads on grant, clears on consume, holds on stall.
// Ports: clk, rst, load (grant), err/data (read result), resp_ready, resp (bundle out).
module rom_resp_slot
    import rom_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        err,
    input  logic [31:0] data,
    input  logic        resp_ready,
    output rom_resp_t   resp
);

    // A load in the consume cycle overwrites the slot, keeping valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp <= '0;
        end else if (load) begin
            resp.valid <= 1'b1;
            resp.err   <= err;
            resp.data  <= err ? 32'h0 : data;
        end else if (resp.valid && resp_ready) begin
            resp.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the ROM word-read port between fetch (if_) and data-load (d_).
// Ports: if_/d_ request+response handshakes, rom_addr/rom_dout to the ROM.
module rom_arbiter
    import rom_pkg::*;
#(
    parameter int          MEM_SIZE  = ROM_SIZE,
    parameter logic [31:0] START_POS = ROM_START,
    parameter int          MAX_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        if_resp_ready,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,
    output logic        d_resp_err,
    input  logic        d_resp_ready,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_dout
);

    localparam logic [31:0] LAST_OFF = 32'(MEM_SIZE - 4);
    localparam logic [3:0]  WAIT_LIM = 4'(MAX_WAIT);

    grant_e      grant;
    rom_resp_t   if_resp;
    rom_resp_t   d_resp;
    logic [3:0]  starve_cnt;
    logic        if_elig;
    logic        d_elig;
    logic [31:0] sel_addr;
    logic [31:0] off;
    logic        in_range;

    // A stalled slot blocks its own side only; pass-through on consume.
    assign if_elig = if_req_valid && (!if_resp.valid || if_resp_ready);
    assign d_elig  = d_req_valid  && (!d_resp.valid  || d_resp_ready);

    always_comb begin
        grant = GRANT_NONE;
        priority case (1'b1)
            rst:               grant = GRANT_NONE;
            (if_elig && d_elig):
                grant = (starve_cnt == WAIT_LIM) ? GRANT_IF : GRANT_D;
            if_elig:           grant = GRANT_IF;
            d_elig:            grant = GRANT_D;
            default:           grant = GRANT_NONE;
        endcase
    end

    assign if_req_ready = (grant == GRANT_IF);
    assign d_req_ready  = (grant == GRANT_D);

    // Idle cycles present the fetch address; the read has no side effects.
    assign sel_addr = (grant == GRANT_D) ? d_req_addr : if_req_addr;
    assign rom_addr = sel_addr & ~32'h3;

    // Wrapping subtract folds "below START_POS" into "offset too large".
    assign off      = rom_addr - START_POS;
    assign in_range = (off <= LAST_OFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!if_req_valid || grant == GRANT_IF) begin
            starve_cnt <= 4'd0;
        end else if (if_elig && starve_cnt != WAIT_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    rom_resp_slot u_if_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (grant == GRANT_IF),
        .err        (!in_range),
        .data       (rom_dout),
        .resp_ready (if_resp_ready),
        .resp       (if_resp)
    );

    rom_resp_slot u_d_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (grant == GRANT_D),
        .err        (!in_range),
        .data       (rom_dout),
        .resp_ready (d_resp_ready),
        .resp       (d_resp)
    );

    assign if_resp_valid = if_resp.valid;
    assign if_resp_err   = if_resp.err;
    assign if_resp_data  = if_resp.data;
    assign d_resp_valid  = d_resp.valid;
    assign d_resp_err    = d_resp.err;
    assign d_resp_data   = d_resp.data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a behavioural ROM and reference model.
// Scenario tasks run in sequence; one summary line at the end.
module tb_rom_arbiter;

    localparam logic [31:0] START = 32'hBFC0_0000;
    localparam int          SIZE  = 4096;
    localparam int          MAXW  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err, if_resp_ready;
    logic [31:0] if_req_addr, if_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_err, d_resp_ready;
    logic [31:0] d_req_addr, d_resp_data;
    logic [31:0] rom_addr, rom_dout, rom_off;

    logic [31:0] rom [0:1023];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: what each response slot should hold, and how many
    // consecutive cycles fetch has been refused while it could have gone.
    logic        m_if_v, m_if_e, m_d_v, m_d_e;
    logic [31:0] m_if_d, m_d_d;
    int          m_wait;

    logic [101:0] obs_v, exp_v;
    logic         obs_if_rdy, obs_d_rdy;

    always #5 clk = ~clk;

    // Behavioural ROM: deliberately returns junk for out-of-range addresses.
    assign rom_off  = rom_addr - START;
    assign rom_dout = rom[rom_off[11:2]];

    rom_arbiter #(.MEM_SIZE(SIZE), .START_POS(START), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .if_resp_ready(if_resp_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr),
        .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
        .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .d_resp_ready(d_resp_ready),
        .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    // {err, data} expected for a byte address, by plain 64-bit range test.
    function automatic logic [32:0] ref_word(input logic [31:0] a);
        longint base;
        longint idx;
        base = longint'({32'h0, a[31:2], 2'b00});
        if (base >= longint'({32'h0, START}) &&
            base + 4 <= longint'({32'h0, START}) + SIZE) begin
            idx = (base - longint'({32'h0, START})) / 4;
            return {1'b0, rom[int'(idx)]};
        end
        return {1'b1, 32'h0};
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(3) != 0)
            return START + 32'($urandom_range(SIZE - 1));
        return $urandom;
    endfunction

    task automatic model_clear();
        m_if_v = 0; m_if_e = 0; m_if_d = 0;
        m_d_v  = 0; m_d_e  = 0; m_d_d  = 0;
        m_wait = 0;
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_req_addr = 0; if_resp_ready = 1;
        d_req_valid  = 0; d_req_addr  = 0; d_resp_ready  = 1;
    endtask

    // One clock cycle: drive, sample request side mid-cycle, advance model,
    // sample response side just after the edge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic ir,
                        input logic dv, input logic [31:0] da, input logic dr);
        logic        if_ok, d_ok;
        int          who;
        logic [31:0] ea;
        logic [32:0] w;
        @(negedge clk);
        if_req_valid = iv; if_req_addr = ia; if_resp_ready = ir;
        d_req_valid  = dv; d_req_addr  = da; d_resp_ready  = dr;
        #1;
        if_ok = iv && (!m_if_v || ir);
        d_ok  = dv && (!m_d_v  || dr);
        who = 0;
        if (if_ok && d_ok) who = (m_wait >= MAXW) ? 1 : 2;
        else if (if_ok)    who = 1;
        else if (d_ok)     who = 2;
        ea = (who == 2) ? da : ia;
        ea[1:0] = 2'b00;
        obs_if_rdy = if_req_ready;
        obs_d_rdy  = d_req_ready;
        obs_v[101:68] = {if_req_ready, d_req_ready, rom_addr};
        exp_v[101:68] = {who == 1, who == 2, ea};
        @(posedge clk);
        if (who == 1) begin
            w = ref_word(ia);
            m_if_v = 1; m_if_e = w[32]; m_if_d = w[31:0];
        end else if (m_if_v && ir) begin
            m_if_v = 0;
        end
        if (who == 2) begin
            w = ref_word(da);
            m_d_v = 1; m_d_e = w[32]; m_d_d = w[31:0];
        end else if (m_d_v && dr) begin
            m_d_v = 0;
        end
        if (!iv || who == 1)              m_wait = 0;
        else if (if_ok && m_wait < MAXW)  m_wait = m_wait + 1;
        #1;
        obs_v[67:0] = {if_resp_valid, if_resp_err, if_resp_data,
                       d_resp_valid, d_resp_err, d_resp_data};
        exp_v[67:0] = {m_if_v, m_if_e, m_if_d, m_d_v, m_d_e, m_d_d};
    endtask

    task automatic test_reset();
        rst = 1;
        if_req_valid = 1; if_req_addr = START; if_resp_ready = 1;
        d_req_valid  = 1; d_req_addr  = START; d_resp_ready  = 1;
        #1;
        tests_run++;
        if ({if_req_ready, d_req_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready got %b want 00", {if_req_ready, d_req_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({if_resp_valid, if_resp_err, if_resp_data,
             d_resp_valid, d_resp_err, d_resp_data} !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_state got %b/%b/%h %b/%b/%h want zeros",
                     if_resp_valid, if_resp_err, if_resp_data,
                     d_resp_valid, d_resp_err, d_resp_data);
        end
        @(negedge clk);
        idle_inputs();
        rst = 0;
        model_clear();
    endtask

    task automatic test_single_fetch();
        step(1, START, 1, 0, 32'h0, 1);
        tests_run++;
        if (obs_v !== exp_v) begin
            tests_failed++;
            $display("FAIL single_fetch got %h want %h", obs_v, exp_v);
        end
        tests_run++;
        if ({obs_if_rdy, if_resp_valid, if_resp_err, if_resp_data} !==
            {1'b1, 1'b1, 1'b0, 32'h0000_0093}) begin
            tests_failed++;
            $display("FAIL single_fetch_word got rdy=%b v=%b e=%b d=%h want 1 1 0 00000093",
                     obs_if_rdy, if_resp_valid, if_resp_err, if_resp_data);
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 12; i++) begin
            step(1, rand_addr(), 1, 1, rand_addr(), 1);
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL starve cyc %0d got %h want %h", i, obs_v, exp_v);
            end
            tests_run++;
            if ({obs_if_rdy, obs_d_rdy} !== {i % 4 == 3, i % 4 != 3}) begin
                tests_failed++;
                $display("FAIL starve_pattern cyc %0d got if=%b d=%b want if=%b",
                         i, obs_if_rdy, obs_d_rdy, i % 4 == 3);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] addrs [4];
        logic [32:0] want  [4];
        logic [31:0] junk;
        junk = 32'h0;
        addrs[0] = 32'hBFC0_0FFE; want[0] = {1'b0, rom[1023]};
        addrs[1] = 32'hBFC0_1000; want[1] = {1'b1, junk};
        addrs[2] = 32'h0000_0000; want[2] = {1'b1, junk};
        addrs[3] = 32'hBFBF_FFFC; want[3] = {1'b1, junk};
        for (int i = 0; i < 4; i++) begin
            step(1, addrs[i], 1, 0, 32'h0, 1);
            tests_run++;
            if (obs_v !== exp_v ||
                {if_resp_err, if_resp_data} !== want[i]) begin
                tests_failed++;
                $display("FAIL range %h got e=%b d=%h want e=%b d=%h",
                         addrs[i], if_resp_err, if_resp_data,
                         want[i][32], want[i][31:0]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        step(0, 32'h0, 1, 1, START + 32'd64, 0);
        held = d_resp_data;
        tests_run++;
        if (obs_v !== exp_v || held !== rom[16]) begin
            tests_failed++;
            $display("FAIL stall_load got %h want %h", obs_v, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, rand_addr(), 1, 1, rand_addr(), 0);
            tests_run++;
            if (obs_v !== exp_v || {obs_if_rdy, obs_d_rdy} !== 2'b10 ||
                d_resp_data !== held || d_resp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall cyc %0d got rdy=%b%b dd=%h want rdy=10 dd=%h",
                         i, obs_if_rdy, obs_d_rdy, d_resp_data, held);
            end
        end
        step(0, 32'h0, 1, 0, 32'h0, 1);
        tests_run++;
        if (obs_v !== exp_v || d_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            a = START + 32'(i * 4);
            step(1, a, 1, 0, 32'h0, 1);
            tests_run++;
            if (obs_v !== exp_v || if_resp_valid !== 1'b1 ||
                if_resp_data !== rom[i]) begin
                tests_failed++;
                $display("FAIL b2b cyc %0d got v=%b d=%h want v=1 d=%h",
                         i, if_resp_valid, if_resp_data, rom[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, START + 32'd8, 0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 1, START + 32'd12, 0);
        tests_run++;
        if ({if_resp_valid, d_resp_valid} !== 2'b11 || obs_v !== exp_v) begin
            tests_failed++;
            $display("FAIL midrst_setup got v=%b%b want 11",
                     if_resp_valid, d_resp_valid);
        end
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        tests_run++;
        if ({if_resp_valid, d_resp_valid, if_req_ready, d_req_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrst_async got v=%b%b rdy=%b%b want 0000",
                     if_resp_valid, d_resp_valid, if_req_ready, d_req_ready);
        end
        @(negedge clk);
        idle_inputs();
        rst = 0;
        model_clear();
        step(1, START + 32'd20, 1, 1, START + 32'd24, 1);
        tests_run++;
        if (obs_v !== exp_v || {obs_if_rdy, obs_d_rdy} !== 2'b01 ||
            d_resp_data !== rom[6] || if_resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_first got rdy=%b%b dd=%h want 01 dd=%h",
                     obs_if_rdy, obs_d_rdy, d_resp_data, rom[6]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3) != 0, rand_addr(), $urandom_range(3) != 0,
                 $urandom_range(3) != 0, rand_addr(), $urandom_range(3) != 0);
            tests_run++;
            if (obs_v !== exp_v) begin
                tests_failed++;
                $display("FAIL random cyc %0d got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0] = 32'h0000_0093;
        model_clear();
        test_reset();
        test_single_fetch();
        test_starvation();
        test_range();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
